seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 13 +
 rtl/seq_multiplier_cla_w.sv | 60 ++++++
 rtl/seq_multiplier.sv | 87 ++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM encoding
// and the default operand width.
package seq_multiplier_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_multiplier_cla_w.sv
// W-bit adder built from 4-bit carry-lookahead blocks with the carry rippled
// between blocks.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // All block carries are formed in parallel from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

module cla_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NBLK = W / 4;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    cla4 u_cla4 (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (sum[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[NBLK];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned W x W sequential multiplier: one shift-and-add step per cycle,
// W cycles per product, product held in DONE until cleared or restarted.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           op_start,
  input  logic           op_clear,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           op_busy,
  output logic           op_done,
  output logic [2*W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  state_t        state;
  state_t        next_state;
  logic [W-1:0]  a_reg;
  logic [CW-1:0] count;
  logic [W-1:0]  sum;
  logic          cout;
  logic [W:0]    upper_next;
  logic          start_ok;
  logic          last_step;

  assign start_ok  = op_start && !op_clear && ((state == IDLE) || (state == DONE));
  assign last_step = (count == CW'(W - 1));

  cla_w #(.W(W)) u_add (
    .a    (result[2*W-1:W]),
    .b    (a_reg),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The carry becomes the new MSB once the register shifts right.
  assign upper_next = result[0] ? {cout, sum} : {1'b0, result[2*W-1:W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (op_clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_start) next_state = EXEC;
        EXEC:    if (last_step) next_state = DONE;
        DONE:    if (op_start) next_state = EXEC;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    op_busy = (state == EXEC);
    op_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg  <= '0;
      result <= '0;
      count  <= '0;
    end else if (op_clear) begin
      result <= '0;
      count  <= '0;
    end else if (start_ok) begin
      a_reg  <= multiplicand;
      result <= {{W{1'b0}}, multiplier};
      count  <= '0;
    end else if (state == EXEC) begin
      result <= {upper_next, result[W-1:1]};
      count  <= count + 1'b1;
    end
  end

endmodule
